// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU select codes and datapath mux encodings. HALT exists only with CTRL_ILLEGAL_TRAP_EN.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BRANCH,
    S_LUI
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALUCTL_ADD   = 3'b000;
  localparam logic [2:0] ALUCTL_SUB   = 3'b001;
  localparam logic [2:0] ALUCTL_AND   = 3'b010;
  localparam logic [2:0] ALUCTL_OR    = 3'b011;
  localparam logic [2:0] ALUCTL_XOR   = 3'b100;
  localparam logic [2:0] ALUCTL_SHIFT = 3'b101;
  localparam logic [2:0] ALUCTL_CMP   = 3'b110;
  localparam logic [2:0] ALUCTL_ZERO  = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: imm_src_of = IMM_I;
      OP_SW:       imm_src_of = IMM_S;
      OP_BR:       imm_src_of = IMM_B;
      OP_JAL:      imm_src_of = IMM_J;
      OP_LUI:      imm_src_of = IMM_U;
      default:     imm_src_of = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_op_decoder.sv
// ALU decoder: maps ALUOp, funct3, funct7[5] and op[5] to the 3-bit ALUControl select.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUCTL_ZERO;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUCTL_ADD;
      ALUOP_SUB: alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7[5] only means subtract for R-type; addi reuses that bit as immediate.
          3'b000:         alu_control = (op_5 & funct7_5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b001, 3'b101: alu_control = ALUCTL_SHIFT;
          3'b010, 3'b011: alu_control = ALUCTL_CMP;
          3'b100:         alu_control = ALUCTL_XOR;
          3'b110:         alu_control = ALUCTL_OR;
          default:        alu_control = ALUCTL_AND;
        endcase
      end
      default: alu_control = ALUCTL_ZERO;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multi-cycle RV32I datapath.
// Optional illegal-opcode trap (HALT state, illegal flag) enabled by CTRL_ILLEGAL_TRAP_EN.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic       pc_update, branch, taken;
  logic       ir_write_s, reg_write_s, mem_write_s;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BRANCH;
          OP_LUI:       state_d = S_LUI;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_update  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_LUI: begin
        ResultSrc   = RES_IMMEXT;
        reg_write_s = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      default: taken = 1'b0;
    endcase
  end

  // Enables are qualified by rst_n so an asserted reset kills any write in the same cycle.
  assign PCWrite  = rst_n & (pc_update | (branch & taken));
  assign IRWrite  = rst_n & ir_write_s;
  assign RegWrite = rst_n & reg_write_s;
  assign MemWrite = rst_n & mem_write_s;
  assign ImmSrc   = imm_src_of(op);

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = rst_n & (state_q == S_HALT);
`else
  assign illegal = 1'b0;
`endif

  alu_op_decoder u_alu_op_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .op_5        (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected control vectors are queued per
// instruction and compared cycle by cycle on the falling clock edge.
module tb_multicycle_controller;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4;
  localparam int ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7, ST_ALUWB = 8, ST_JAL = 9;
  localparam int ST_BRANCH = 10, ST_LUI = 11, ST_HALT = 12, ST_RESET = 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;

  int vec_count = 0;
  int err_count = 0;
  logic [17:0] sb_q[$];

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_imm(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 3'b000;
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] model_funct(input logic [6:0] o, input logic [2:0] f3, input logic f75);
    case (f3)
      3'b000:         return (o[5] && f75) ? 3'b001 : 3'b000;
      3'b001, 3'b101: return 3'b101;
      3'b010, 3'b011: return 3'b110;
      3'b100:         return 3'b100;
      3'b110:         return 3'b011;
      default:        return 3'b010;
    endcase
  endfunction

  // Expected {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
  function automatic logic [17:0] exp_vec(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f75, input logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0;
    logic [2:0] ac = 0;
    case (st)
      ST_FETCH:    begin irw = 1; pcw = 1; sb = 2; rs = 2; end
      ST_DECODE:   begin sa = 1; sb = 1; end
      ST_MEMADR:   begin sa = 2; sb = 1; end
      ST_MEMREAD:  adr = 1;
      ST_MEMWB:    begin rs = 1; rw = 1; end
      ST_MEMWRITE: begin adr = 1; mw = 1; end
      ST_EXECR:    begin sa = 2; sb = 0; ac = model_funct(o, f3, f75); end
      ST_EXECI:    begin sa = 2; sb = 1; ac = model_funct(o, f3, f75); end
      ST_ALUWB:    rw = 1;
      ST_JAL:      begin sa = 1; sb = 2; pcw = 1; end
      ST_BRANCH:   begin sa = 2; ac = 3'b001; pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0); end
      ST_LUI:      begin rs = 3; rw = 1; end
      ST_HALT:     ill = 1;
      ST_RESET:    begin rs = 2; sb = 2; end
      default:     ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, model_imm(o), ac, ill};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ImmSrc, ALUControl, illegal};
  endfunction

  task automatic push_state(input int st);
    sb_q.push_back(exp_vec(st, op, funct3, funct7_5, Zero));
  endtask

  task automatic pop_check(input string tag);
    logic [17:0] e;
    if (sb_q.size() == 0) begin
      vec_count++;
      err_count++;
      $display("FAIL %s: scoreboard empty, got %05h expected a queued vector", tag, obs_vec());
    end else begin
      e = sb_q.pop_front();
      check_vec(tag, obs_vec(), e);
    end
  endtask

  // Entered in the low half of a FETCH cycle; leaves at the next FETCH falling edge.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f75, input logic z, input int n, input int seq[6]);
    op = o; funct3 = f3; funct7_5 = f75; Zero = z;
    for (int i = 0; i < n; i++) push_state(seq[i]);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      pop_check($sformatf("%s.c%0d", name, i));
    end
    $display("instr %s op=%07b f3=%03b f7=%0b z=%0b cycles=%0d", name, o, f3, f75, z, n);
    @(negedge clk);
  endtask

  task automatic reset_pulse(input string name);
    rst_n = 1'b0;
    #1;
    push_state(ST_RESET);
    pop_check({name, ".rst0"});
    @(negedge clk);
    #1;
    push_state(ST_RESET);
    pop_check({name, ".rst1"});
    rst_n = 1'b1;
  endtask

  int seq_r[6]   = '{ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB, 0, 0};
  int seq_i[6]   = '{ST_FETCH, ST_DECODE, ST_EXECI, ST_ALUWB, 0, 0};
  int seq_lw[6]  = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, 0};
  int seq_sw[6]  = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWRITE, 0, 0};
  int seq_br[6]  = '{ST_FETCH, ST_DECODE, ST_BRANCH, 0, 0, 0};
  int seq_jal[6] = '{ST_FETCH, ST_DECODE, ST_JAL, ST_ALUWB, 0, 0};
  int seq_lui[6] = '{ST_FETCH, ST_DECODE, ST_LUI, 0, 0, 0};
  int seq_ill[6] = '{ST_FETCH, ST_DECODE, 0, 0, 0, 0};

  initial begin
    @(negedge clk);
    #1;
    push_state(ST_RESET);
    pop_check("reset0");
    @(negedge clk);
    #1;
    push_state(ST_RESET);
    pop_check("reset1");
    rst_n = 1'b1;

    run_instr("add",  7'b0110011, 3'b000, 1'b0, 1'b0, 4, seq_r);
    run_instr("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 4, seq_r);
    run_instr("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, seq_i);
    run_instr("srai", 7'b0010011, 3'b101, 1'b1, 1'b0, 4, seq_i);
    run_instr("slt",  7'b0110011, 3'b010, 1'b0, 1'b0, 4, seq_r);
    run_instr("xor",  7'b0110011, 3'b100, 1'b0, 1'b0, 4, seq_r);
    run_instr("or",   7'b0110011, 3'b110, 1'b0, 1'b0, 4, seq_r);
    run_instr("and",  7'b0110011, 3'b111, 1'b0, 1'b0, 4, seq_r);
    run_instr("sll",  7'b0110011, 3'b001, 1'b0, 1'b0, 4, seq_r);
    run_instr("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 5, seq_lw);
    run_instr("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 4, seq_sw);
    run_instr("beq1", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, seq_br);
    run_instr("beq0", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, seq_br);
    run_instr("bne0", 7'b1100011, 3'b001, 1'b0, 1'b0, 3, seq_br);
    run_instr("bne1", 7'b1100011, 3'b001, 1'b0, 1'b1, 3, seq_br);
    run_instr("blt0", 7'b1100011, 3'b100, 1'b0, 1'b0, 3, seq_br);
    run_instr("blt1", 7'b1100011, 3'b100, 1'b0, 1'b1, 3, seq_br);
    run_instr("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 4, seq_jal);
    run_instr("lui",  7'b0110111, 3'b000, 1'b0, 1'b0, 3, seq_lui);

`ifdef CTRL_ILLEGAL_TRAP_EN
    op = 7'b0000000; funct3 = 3'b000; funct7_5 = 1'b0; Zero = 1'b0;
    push_state(ST_FETCH);
    push_state(ST_DECODE);
    for (int i = 0; i < 4; i++) push_state(ST_HALT);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      pop_check($sformatf("halt.c%0d", i));
    end
    $display("instr illegal op=0000000 trapped, illegal held 4 cycles");
    @(negedge clk);
    reset_pulse("halt");
`else
    run_instr("illegal", 7'b0000000, 3'b000, 1'b0, 1'b0, 2, seq_ill);
`endif
    run_instr("add2", 7'b0110011, 3'b000, 1'b0, 1'b0, 4, seq_r);

    // Reset asserted while MEMWRITE is active must kill the store at once.
    op = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0; Zero = 1'b0;
    for (int i = 0; i < 4; i++) push_state(seq_sw[i]);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      pop_check($sformatf("swrst.c%0d", i));
    end
    reset_pulse("swrst");
    $display("instr sw aborted by reset in MEMWRITE");
    op = 7'b0110011;
    #1;
    check_vec("post_rst_irwrite", {17'd0, IRWrite}, 18'd1);
    run_instr("add3", 7'b0110011, 3'b000, 1'b0, 1'b0, 4, seq_r);
    run_instr("lui2", 7'b0110111, 3'b000, 1'b0, 1'b0, 3, seq_lui);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
